// File: rtl/bcd_to_binary_converter.sv
// bcd_to_binary_converter: sequential reverse-double-dabble, 3 packed BCD digits to 10-bit binary
module bcd_to_binary_converter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    output logic       busy,
    output logic       done,
    output logic [9:0] binary,
    output logic       error
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t      r_state;
    logic [11:0] r_bcd;
    logic [9:0]  r_bin;
    logic [3:0]  r_cnt;
    logic        r_invalid;

    logic [21:0] w_shift;
    logic [11:0] w_bcd_adj;
    logic        w_invalid;

    function automatic logic [3:0] adj(input logic [3:0] n);
        return (n >= 4'd8) ? n - 4'd3 : n;
    endfunction

    // One iteration: shift {bcd,bin} right, then correct each digit nibble on its own
    always_comb begin
        w_shift   = {r_bcd, r_bin} >> 1;
        w_bcd_adj = {adj(w_shift[21:18]), adj(w_shift[17:14]), adj(w_shift[13:10])};
        w_invalid = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
    end

    // Control FSM and datapath; the DONE cycle also accepts start so held-start restarts every 11 cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_invalid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            binary    <= '0;
            error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state   <= S_SHIFT;
                        r_bcd     <= {hundreds, tens, ones};
                        r_bin     <= '0;
                        r_cnt     <= '0;
                        r_invalid <= w_invalid;
                        busy      <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_shift[9:0];
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        binary  <= r_invalid ? 10'd0 : w_shift[9:0];
                        error   <= r_invalid;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// tb_bcd_to_binary_converter: table-driven scoreboard bench for the BCD-to-binary converter
`timescale 1ns/1ps
module tb_bcd_to_binary_converter;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] ones = '0, tens = '0, hundreds = '0;
    logic       busy, done, error;
    logic [9:0] binary;

    typedef struct {
        logic [3:0] h, t, o;
        logic [9:0] b;
        logic       e;
    } vec_t;

    typedef struct {
        logic [9:0] b;
        logic       e;
        time        t;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;
    int   bcnt = 0;
    logic prev_done = 1'b0;
    time  last_done_t = 0;
    time  done_gap = 0;

    bcd_to_binary_converter dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .ones(ones), .tens(tens), .hundreds(hundreds),
        .busy(busy), .done(done), .binary(binary), .error(error)
    );

    always #5 clk = ~clk;

    // Output monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (!reset_n) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                done_gap = $time - last_done_t;
                last_done_t = $time;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=1 with nothing pending, required done=0");
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    checks++;
                    if (binary !== x.b) begin
                        errors++;
                        $display("FAIL binary: got %0d required %0d", binary, x.b);
                    end
                    checks++;
                    if (error !== x.e) begin
                        errors++;
                        $display("FAIL error_flag: got %b required %b", error, x.e);
                    end
                    checks++;
                    if ($time - x.t != 110) begin
                        errors++;
                        $display("FAIL latency: got %0t required 110 (11 half-shifted periods)", $time - x.t);
                    end
                    checks++;
                    if (bcnt != 10 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_cycles: got %0d busy_now=%b required 10 busy_now=0", bcnt, busy);
                    end
                    checks++;
                    if (prev_done !== 1'b0) begin
                        errors++;
                        $display("FAIL done_pulse: done high two cycles in a row, required one-cycle pulse");
                    end
                end
                bcnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic wait_empty();
        for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL timeout: %0d conversions still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic convert(input logic [3:0] h, t, o, input logic [9:0] b, input logic e);
        @(negedge clk);
        hundreds = h; tens = t; ones = o; start = 1'b1;
        sb.push_back('{b, e, $time});
        @(negedge clk);
        start = 1'b0;
        hundreds = 4'($urandom); tens = 4'($urandom); ones = 4'($urandom);
        wait_empty();
    endtask

    task automatic check_idle(input string name, input logic [9:0] b, input logic e);
        checks++;
        if ({busy, done, binary, error} !== {1'b0, 1'b0, b, e}) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b binary=%0d error=%b required 0 0 %0d %b",
                     name, busy, done, binary, error, b, e);
        end
    endtask

    initial begin
        vecs = '{
            '{4'd9, 4'd9, 4'd9, 10'd999, 1'b0},
            '{4'd0, 4'd0, 4'd0, 10'd0,   1'b0},
            '{4'd1, 4'hA, 4'd3, 10'd0,   1'b1},
            '{4'd0, 4'd4, 4'd2, 10'd42,  1'b0},
            '{4'd2, 4'd5, 4'd5, 10'd255, 1'b0},
            '{4'd1, 4'd0, 4'd0, 10'd100, 1'b0},
            '{4'd0, 4'd1, 4'd0, 10'd10,  1'b0},
            '{4'd5, 4'd1, 4'd2, 10'd512, 1'b0},
            '{4'd7, 4'd8, 4'd9, 10'd789, 1'b0},
            '{4'd0, 4'd0, 4'd1, 10'd1,   1'b0},
            '{4'd9, 4'd0, 4'd9, 10'd909, 1'b0},
            '{4'd9, 4'hF, 4'd0, 10'd0,   1'b1},
            '{4'hC, 4'd0, 4'd0, 10'd0,   1'b1},
            '{4'd3, 4'd6, 4'd8, 10'd368, 1'b0}
        };
        #1 check_idle("reset_state", 10'd0, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) convert(vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].b, vecs[i].e);

        // Held start: 255 then 100 accepted at edge 11, done pulses 11 cycles apart
        @(negedge clk);
        hundreds = 4'd2; tens = 4'd5; ones = 4'd5; start = 1'b1;
        sb.push_back('{10'd255, 1'b0, $time});
        repeat (11) @(negedge clk);
        hundreds = 4'd1; tens = 4'd0; ones = 4'd0;
        sb.push_back('{10'd100, 1'b0, $time});
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        checks++;
        if (done_gap != 110) begin
            errors++;
            $display("FAIL done_gap: got %0t required 110", done_gap);
        end

        // Extra start pulses at edges 3 and 10 with different digits are ignored
        @(negedge clk);
        hundreds = 4'd1; tens = 4'd2; ones = 4'd3; start = 1'b1;
        sb.push_back('{10'd123, 1'b0, $time});
        @(negedge clk);
        start = 1'b0; hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        repeat (3) @(negedge clk);
        check_idle("ignored_starts_idle", 10'd123, 1'b0);

        // Reset in the middle of SHIFT aborts immediately
        @(negedge clk);
        hundreds = 4'd5; tens = 4'd0; ones = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1 check_idle("async_reset", 10'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check_idle("no_done_after_abort", 10'd0, 1'b0);
        convert(4'd5, 4'd0, 4'd0, 10'd500, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
